count_up_0_30: RTL and testbench
================================

COUNT_UP_0_30 -- requirements
Module: count_up_0_30

Interface
REQ-001 SHALL have parameter LIMIT_DOZENS, default 3, meaning tens digit of terminal count (0..3).
REQ-002 SHALL have parameter LIMIT_UNITS, default 0, meaning units digit of terminal count (0..9).
REQ-003 SHALL have port clock  input  1  sole clock, rising-edge active.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  count-advance request, sampled on rising clock.
REQ-006 SHALL have port load  input  1  synchronous load strobe.
REQ-007 SHALL have port load_value  input  6  BCD load value: [5:4] dozens, [3:0] units.
REQ-008 SHALL have port dozens  output  2  BCD tens digit of count, registered.
REQ-009 SHALL have port units  output  4  BCD units digit of count, registered.
REQ-010 SHALL have port at_limit  output  1  level, high while count equals terminal count.
REQ-011 SHALL have port done  output  1  one-cycle pulse on the edge where count becomes terminal through increment.
REQ-012 SHALL have port load_err  output  1  one-cycle pulse flagging a rejected or clamped load.

Function
REQ-013 SHALL count up in BCD: units 0..9, and on units 9 plus increment, units go to 0 and dozens increment in the same edge.
REQ-014 SHALL never hold units above 9 or the count above terminal count LIMIT_DOZENS:LIMIT_UNITS.
REQ-015 SHALL increment by exactly one per rising edge with enable=1 and load=0; count is visible on outputs the cycle after the edge (one-edge latency).
REQ-016 SHALL give load priority over enable; on load=1 the count takes load_value at the next edge, with no increment that cycle.
REQ-017 SHALL clamp to terminal count, and pulse load_err for one cycle, when load_value units exceed 9 or load_value exceeds the terminal count.
REQ-018 SHALL drive at_limit combinationally from the registered count only.
REQ-019 SHALL assert done for exactly one cycle after the increment edge that produces terminal count; a load to terminal count SHALL NOT assert done.
REQ-020 SHALL treat enable at terminal count as the wrap/hold event defined under Configuration; done SHALL NOT re-pulse while holding.
REQ-021 SHALL be a two-state machine: COUNTING (count < limit) and AT_LIMIT (count == limit). COUNTING goes to AT_LIMIT on increment or load reaching the limit. AT_LIMIT goes to COUNTING on load below the limit or on wrap.
REQ-022 SHALL, with LIMIT 00, stay at 00 with at_limit=1, and wrap or hold per Configuration.

Reset
REQ-023 SHALL, on reset=0, immediately and asynchronously force dozens=0, units=0, done=0, load_err=0, and state COUNTING (AT_LIMIT if LIMIT is 00).
REQ-024 SHALL ignore enable and load while reset=0, including a reset asserted mid-count.
REQ-025 SHALL resume counting on the first rising edge after reset deasserts.

Configuration
REQ-026 SHALL honour macro COUNT_UP_AUTO_WRAP_EN. When defined, enable at terminal count sets the count to 00 at the next edge, and done pulses at each new arrival at the limit. When undefined, enable at terminal count holds the count and only a load or reset leaves the terminal count.

Verification
REQ-027 SHALL cover: reset, then 30 enabled edges -> count 00,01..09,10..30; done high only in the cycle after reaching 30; at_limit=1.
REQ-028 SHALL cover: count 30 plus one more enabled edge -> 00 with COUNT_UP_AUTO_WRAP_EN, 30 held without it; done stays 0 on that edge.
REQ-029 SHALL cover: load=1, enable=1, load_value=6'h19 -> count 19 at next edge; next enabled edge -> 20.
REQ-030 SHALL cover: load_value=6'h0C or 6'h35 -> count 30, load_err pulses one cycle, done stays 0.
REQ-031 SHALL cover: reset driven low between clock edges at count 17 -> outputs 00 before the next edge; enable ignored until reset returns high.
REQ-032 SHALL cover: enable toggled every other cycle from 08 -> 09, then 10, with dozens and units changing on the same edge.

Source files
------------

// File: rtl/count_up_0_30.sv
// BCD up-counter (dozens:units) with synchronous load, clamp-on-bad-load and terminal-count flags.
// Optional: define COUNT_UP_AUTO_WRAP_EN to wrap to 00 on enable at terminal count (default: hold).
module count_up_0_30 #(
    parameter int unsigned LIMIT_DOZENS = 3,
    parameter int unsigned LIMIT_UNITS  = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       load,
    input  logic [5:0] load_value,
    output logic [1:0] dozens,
    output logic [3:0] units,
    output logic       at_limit,
    output logic       done,
    output logic       load_err
);

    localparam int unsigned DW = 2;
    localparam int unsigned UW = 4;
    localparam int unsigned CW = DW + UW;

    localparam logic [DW-1:0] LIM_D      = DW'(LIMIT_DOZENS);
    localparam logic [UW-1:0] LIM_U      = UW'(LIMIT_UNITS);
    localparam logic [CW-1:0] LIMIT      = {LIM_D, LIM_U};
    localparam bit            LIMIT_ZERO = (LIMIT == CW'(0));

    typedef enum logic {
        COUNTING = 1'b0,
        AT_LIMIT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d, count_inc;
    logic          done_d, err_d;

    assign dozens   = count_q[CW-1:UW];
    assign units    = count_q[UW-1:0];
    assign at_limit = (count_q == LIMIT);

    // BCD increment: units carry into dozens on the same edge
    always_comb begin
        count_inc = count_q;
        if (count_q[UW-1:0] == UW'(9)) begin
            count_inc = {DW'(count_q[CW-1:UW] + DW'(1)), UW'(0)};
        end else begin
            count_inc = {count_q[CW-1:UW], UW'(count_q[UW-1:0] + UW'(1))};
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (load) begin
            // Packed BCD compares numerically once the units digit is known valid
            if ((load_value[UW-1:0] > UW'(9)) || (load_value > LIMIT)) begin
                count_d = LIMIT;
                err_d   = 1'b1;
            end else begin
                count_d = load_value;
            end
            state_d = (count_d == LIMIT) ? AT_LIMIT : COUNTING;
        end else if (enable) begin
            case (state_q)
                COUNTING: begin
                    count_d = count_inc;
                    if (count_inc == LIMIT) begin
                        state_d = AT_LIMIT;
                        done_d  = 1'b1;
                    end
                end
                AT_LIMIT: begin
`ifdef COUNT_UP_AUTO_WRAP_EN
                    count_d = CW'(0);
                    state_d = LIMIT_ZERO ? AT_LIMIT : COUNTING;
`else
                    count_d = count_q;
`endif
                end
                default: state_d = COUNTING;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= LIMIT_ZERO ? AT_LIMIT : COUNTING;
            count_q  <= CW'(0);
            done     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            done     <= done_d;
            load_err <= err_d;
        end
    end

endmodule

// File: tb/tb_count_up_0_30.sv
// Scoreboard bench for count_up_0_30 with default limit 30; decimal reference model.
module tb_count_up_0_30;

    localparam int LIM = 30;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       load;
    logic [5:0] load_value;
    logic [1:0] dozens;
    logic [3:0] units;
    logic       at_limit;
    logic       done;
    logic       load_err;

    int         checks;
    int         errors;
    int         cnt;
    logic [8:0] exp_q[$];
    string      name_q[$];

    count_up_0_30 dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .load_value (load_value),
        .dozens     (dozens),
        .units      (units),
        .at_limit   (at_limit),
        .done       (done),
        .load_err   (load_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one cycle, predict with the model, then compare after the edge
    task automatic step(input logic en, input logic ld, input logic [5:0] lv, input string nm);
        logic       e_done;
        logic       e_err;
        int         lu;
        int         lval;
        logic [8:0] exp;
        logic [8:0] got;
        string      n;
        @(negedge clock);
        enable     = en;
        load       = ld;
        load_value = lv;
        e_done     = 1'b0;
        e_err      = 1'b0;
        if (ld) begin
            lu   = int'(lv[3:0]);
            lval = int'(lv[5:4]) * 10 + lu;
            if (lu > 9 || lval > LIM) begin
                cnt   = LIM;
                e_err = 1'b1;
            end else begin
                cnt = lval;
            end
        end else if (en) begin
            if (cnt == LIM) begin
`ifdef COUNT_UP_AUTO_WRAP_EN
                cnt = 0;
`else
                cnt = LIM;
`endif
            end else begin
                cnt = cnt + 1;
                if (cnt == LIM) e_done = 1'b1;
            end
        end
        exp_q.push_back({2'(cnt / 10), 4'(cnt % 10), 1'(cnt == LIM), e_done, e_err});
        name_q.push_back(nm);
        @(posedge clock);
        #1;
        exp = exp_q.pop_front();
        n   = name_q.pop_front();
        got = {dozens, units, at_limit, done, load_err};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got d=%0d u=%0d lim=%b done=%b err=%b, expected d=%0d u=%0d lim=%b done=%b err=%b",
                     n, got[8:7], got[6:3], got[2], got[1], got[0],
                     exp[8:7], exp[6:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        enable     = 1'b1;
        load       = 1'b0;
        load_value = 6'h00;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({dozens, units, at_limit, done, load_err} !== 9'b0) begin
            errors++;
            $display("FAIL reset_state: got d=%0d u=%0d lim=%b done=%b err=%b, expected all 0",
                     dozens, units, at_limit, done, load_err);
        end
        @(negedge clock);
        enable = 1'b0;
        reset  = 1'b1;
        cnt    = 0;
    endtask

    task automatic test_count_to_limit();
        for (int i = 1; i <= LIM; i++) step(1'b1, 1'b0, 6'h00, $sformatf("count_%0d", i));
    endtask

    task automatic test_limit_enable();
        step(1'b1, 1'b0, 6'h00, "enable_at_limit");
        step(1'b0, 1'b0, 6'h00, "idle_after_limit");
    endtask

    task automatic test_load();
        step(1'b1, 1'b1, 6'h19, "load_19_priority");
        step(1'b1, 1'b0, 6'h00, "inc_19_to_20");
    endtask

    task automatic test_load_clamp();
        step(1'b0, 1'b1, 6'h0C, "load_0C_clamp");
        step(1'b0, 1'b0, 6'h00, "err_one_cycle");
        step(1'b0, 1'b1, 6'h12, "load_12");
        step(1'b1, 1'b1, 6'h35, "load_35_clamp");
        step(1'b0, 1'b1, 6'h05, "load_below_limit");
        step(1'b0, 1'b1, 6'h30, "load_exact_limit");
        step(1'b1, 1'b1, 6'h29, "load_29");
        step(1'b1, 1'b0, 6'h00, "inc_to_limit_after_load");
    endtask

    task automatic test_reset_mid_count();
        step(1'b0, 1'b1, 6'h17, "load_17");
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if ({dozens, units, at_limit, done, load_err} !== 9'b0) begin
            errors++;
            $display("FAIL async_reset_17: got d=%0d u=%0d lim=%b done=%b err=%b, expected all 0",
                     dozens, units, at_limit, done, load_err);
        end
        enable     = 1'b1;
        load       = 1'b1;
        load_value = 6'h25;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            checks++;
            if ({dozens, units, done, load_err} !== 8'b0) begin
                errors++;
                $display("FAIL reset_hold_%0d: got d=%0d u=%0d done=%b err=%b, expected 0",
                         i, dozens, units, done, load_err);
            end
        end
        @(negedge clock);
        enable = 1'b0;
        load   = 1'b0;
        reset  = 1'b1;
        cnt    = 0;
        step(1'b1, 1'b0, 6'h00, "resume_after_reset");
    endtask

    task automatic test_bcd_carry();
        step(1'b0, 1'b1, 6'h08, "load_08");
        step(1'b1, 1'b0, 6'h00, "inc_08_to_09");
        step(1'b0, 1'b0, 6'h00, "hold_09");
        step(1'b1, 1'b0, 6'h00, "carry_09_to_10");
        step(1'b0, 1'b0, 6'h00, "hold_10");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cnt    = 0;
        test_reset();
        test_count_to_limit();
        test_limit_enable();
        test_load();
        test_load_clamp();
        test_reset_mid_count();
        test_bcd_carry();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
